button_arbiter: RTL and testbench

BUTTON_ARBITER -- requirements
Module: button_arbiter

---
 rtl/io_pkg.sv | 37 +++
 rtl/button_arbiter_if.sv | 32 +++
 rtl/btn_debounce.sv | 52 +++++
 rtl/button_arbiter.sv | 146 ++++++++++++++
 tb/tb_button_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// io_pkg -- shared constants and helpers for the pushbutton front end.
//
// Contents:
//   UP/LEFT/RIGHT/CONFIRM : bit index of each button in every 4-bit vector
//                           (MSB = up, LSB = confirm).
//   NUM_BTN               : number of buttons (4).
//   CNT_W                 : debounce counter width (20 bits, DEBOUNCE_CYCLES < 2^20).
//   prio_grant()          : fixed-priority one-hot grant, up > left > right > confirm.
package io_pkg;

  localparam int UP      = 3;
  localparam int LEFT    = 2;
  localparam int RIGHT   = 1;
  localparam int CONFIRM = 0;

  localparam int NUM_BTN = 4;
  localparam int CNT_W   = 20;

  // One-hot grant of the highest-priority requester; all zero when idle.
  function automatic logic [NUM_BTN-1:0] prio_grant(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] g;
    g = 4'b0000;
    if (req[UP]) begin
      g[UP] = 1'b1;
    end else if (req[LEFT]) begin
      g[LEFT] = 1'b1;
    end else if (req[RIGHT]) begin
      g[RIGHT] = 1'b1;
    end else if (req[CONFIRM]) begin
      g[CONFIRM] = 1'b1;
    end else begin
      g = 4'b0000;
    end
    return g;
  endfunction

endpackage

// File: rtl/button_arbiter_if.sv
// button_arbiter_if -- raw pushbuttons in, event pulses and pending flags out.
//
// Signals:
//   btn_up/left/right/confirm : raw, bouncing, asynchronous pushbuttons.
//   up_o/left_o/right_o/confirm_o : single-cycle event pulses (at most one high).
//   pending_o[3:0]             : registered pending flags {up,left,right,confirm}.
// Modports:
//   master : the button/board side (drives buttons, observes events).
//   slave  : the arbiter itself.
interface button_arbiter_if;

  logic       btn_up;
  logic       btn_left;
  logic       btn_right;
  logic       btn_confirm;
  logic       up_o;
  logic       left_o;
  logic       right_o;
  logic       confirm_o;
  logic [3:0] pending_o;

  modport master (
    output btn_up, btn_left, btn_right, btn_confirm,
    input  up_o, left_o, right_o, confirm_o, pending_o
  );

  modport slave (
    input  btn_up, btn_left, btn_right, btn_confirm,
    output up_o, left_o, right_o, confirm_o, pending_o
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce -- 2-flop synchronizer followed by a counting debouncer.
//
// Ports:
//   clk    : system clock, rising edge.
//   rst    : asynchronous active-low reset; clears synchronizer, level and counter.
//   raw    : raw pushbutton, asynchronous and bouncing.
//   stable : debounced level; flips only after DEBOUNCE_CYCLES consecutive
//            synchronized samples that differ from the current level.
module btn_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronizer chain plus debounce counter; any sample equal to the
  // current level restarts the count, so a bounce never accumulates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/button_arbiter.sv
// button_arbiter -- debounces four pushbuttons and serialises their press
// events into single-cycle pulses for the mode/state shifter.
//
// Ports:
//   clk : system clock, rising edge.
//   rst : asynchronous active-low reset.
//   bus : button_arbiter_if.slave (raw buttons in; event pulses and
//         pending flags out, see the interface header).
//
// Each rising debounced level sets a pending flag; one flag per cycle is
// granted with fixed priority up > left > right > confirm, and the grant is
// registered into the matching output pulse while the flag is cleared.
//
// Optional feature, macro BUTTON_AUTOREPEAT_EN: left and right re-raise their
// pending flag after REPEAT_DELAY held cycles, then every REPEAT_PERIOD
// cycles while still held. Without the macro no repeat logic is built.
module button_arbiter
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                   clk,
  input  logic                   rst,
  button_arbiter_if.slave        bus
);

  logic [NUM_BTN-1:0] raw_s;
  logic [NUM_BTN-1:0] stable_s;
  logic [NUM_BTN-1:0] stable_d_r;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] rpt_ev_s;
  logic [NUM_BTN-1:0] event_s;
  logic [NUM_BTN-1:0] grant_s;
  logic [NUM_BTN-1:0] pending_nxt_s;
  logic [NUM_BTN-1:0] pending_r;
  logic [NUM_BTN-1:0] out_r;

  assign raw_s = {bus.btn_up, bus.btn_left, bus.btn_right, bus.btn_confirm};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_s[i]),
      .stable (stable_s[i])
    );
  end

  // Delayed copy of the debounced levels for 0->1 edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d_r <= 4'b0000;
    end else begin
      stable_d_r <= stable_s;
    end
  end

  // Only a press (rising level) is an event; releases are ignored.
  assign rise_s = stable_s & ~stable_d_r;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);

  for (genvar k = 0; k < 2; k++) begin : g_rpt
    localparam int B = (k == 0) ? RIGHT : LEFT;

    // cnt_r = cycles elapsed since the last event of this button (press or
    // repeat); armed_r marks that the initial delay has already elapsed.
    logic [RPT_W-1:0] cnt_r;
    logic             armed_r;
    logic             fire_s;

    // Repeat fires when the held time reaches the current threshold.
    always_comb begin
      fire_s = 1'b0;
      if (stable_s[B]) begin
        if (armed_r) begin
          fire_s = (cnt_r == RPT_PERIOD_C);
        end else begin
          fire_s = (cnt_r == RPT_DELAY_C);
        end
      end else begin
        fire_s = 1'b0;
      end
    end

    // Repeat timer: idle while released, reloads to one on each repeat.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_r   <= '0;
        armed_r <= 1'b0;
      end else if (!stable_s[B]) begin
        cnt_r   <= '0;
        armed_r <= 1'b0;
      end else if (fire_s) begin
        cnt_r   <= RPT_ONE;
        armed_r <= 1'b1;
      end else begin
        cnt_r   <= cnt_r + RPT_ONE;
      end
    end

    assign rpt_ev_s[B] = fire_s;
  end

  assign rpt_ev_s[UP]      = 1'b0;
  assign rpt_ev_s[CONFIRM] = 1'b0;
`else
  assign rpt_ev_s = 4'b0000;
`endif

  assign event_s = rise_s | rpt_ev_s;

  // Grant and next pending state; a new event beats the clear of its own
  // grant, and repeated events simply merge into the already-set flag.
  always_comb begin
    grant_s       = prio_grant(pending_r);
    pending_nxt_s = (pending_r & ~grant_s) | event_s;
  end

  // Pending flags and registered one-hot output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r <= 4'b0000;
      out_r     <= 4'b0000;
    end else begin
      pending_r <= pending_nxt_s;
      out_r     <= grant_s;
    end
  end

  assign bus.up_o      = out_r[UP];
  assign bus.left_o    = out_r[LEFT];
  assign bus.right_o   = out_r[RIGHT];
  assign bus.confirm_o = out_r[CONFIRM];
  assign bus.pending_o = pending_r;

endmodule

// File: tb/tb_button_arbiter.sv
// Bench for button_arbiter with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3. Cycle numbering: cyc counts rising edges; inputs change and
// outputs are sampled on the falling edge. A button driven at cyc=b is first
// sampled at edge b+1, so its output pulse is due at cyc=b+8
// (2 sync + 4 debounce + 1 pending + 1 output), i.e. 7 cycles after that edge.
module tb_button_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  button_arbiter_if bus ();

  button_arbiter #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [3:0]      btns;
    int              hold;
    int              n_ev;
    logic [5:0][7:0] off;
    logic [5:0][3:0] vec;
  } row_t;

  row_t rows[8];

  function automatic logic [3:0] outs();
    return {bus.up_o, bus.left_o, bus.right_o, bus.confirm_o};
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  task automatic check_q_empty(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d_unseen_pulses required=0", name, cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // One falling edge: pop the pulse due now (if any), else expect silence.
  task automatic tick();
    logic [3:0] exp_v;
    exp_t       e;
    @(negedge clk);
    exp_v = 4'b0000;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e     = exp_q.pop_front();
      exp_v = e.vec;
    end
    check4("pulses", outs(), exp_v);
  endtask

  task automatic set_btn(input logic [3:0] b);
    bus.btn_up      = b[3];
    bus.btn_left    = b[2];
    bus.btn_right   = b[1];
    bus.btn_confirm = b[0];
  endtask

  task automatic def_row(input int r, input logic [3:0] b, input int h);
    rows[r].btns = b;
    rows[r].hold = h;
    rows[r].n_ev = 0;
    rows[r].off  = '0;
    rows[r].vec  = '0;
  endtask

  task automatic add_ev(input int r, input int o, input logic [3:0] v);
    rows[r].off[rows[r].n_ev] = o[7:0];
    rows[r].vec[rows[r].n_ev] = v;
    rows[r].n_ev++;
  endtask

  task automatic run_row(input int r);
    int base;
    base = cyc;
    set_btn(rows[r].btns);
    for (int i = 0; i < rows[r].n_ev; i++) push(base + int'(rows[r].off[i]), rows[r].vec[i]);
    repeat (rows[r].hold) tick();
    set_btn(4'b0000);
    while (cyc < base + 40) tick();
    check4("pend_idle", bus.pending_o, 4'b0000);
    check_q_empty("row_pulses_seen");
  endtask

  initial begin
    int base;
    int r;

    set_btn(4'b0000);
    rst = 1'b0;
    repeat (3) begin
      tick();
      check4("pend_in_reset", bus.pending_o, 4'b0000);
    end
    rst = 1'b1;
    tick();
    check4("pend_after_reset", bus.pending_o, 4'b0000);

    // Stimulus table: {buttons {up,left,right,confirm}, held cycles, pulses}.
    def_row(0, 4'b0100, 10); add_ev(0, 8, 4'b0100);
`ifdef BUTTON_AUTOREPEAT_EN
    add_ev(0, 16, 4'b0100);
`endif
    def_row(1, 4'b1000, 10); add_ev(1, 8, 4'b1000);
    def_row(2, 4'b0001, 3);                            // one cycle short: no event
    def_row(3, 4'b0010, 4);  add_ev(3, 8, 4'b0010);    // exactly long enough
    def_row(4, 4'b0110, 10); add_ev(4, 8, 4'b0100); add_ev(4, 9, 4'b0010);
`ifdef BUTTON_AUTOREPEAT_EN
    add_ev(4, 16, 4'b0100); add_ev(4, 17, 4'b0010);
`endif
    def_row(5, 4'b1111, 10);
    add_ev(5, 8, 4'b1000); add_ev(5, 9, 4'b0100); add_ev(5, 10, 4'b0010); add_ev(5, 11, 4'b0001);
`ifdef BUTTON_AUTOREPEAT_EN
    add_ev(5, 16, 4'b0100); add_ev(5, 17, 4'b0010);
`endif
    def_row(6, 4'b0010, 20); add_ev(6, 8, 4'b0010);
`ifdef BUTTON_AUTOREPEAT_EN
    add_ev(6, 16, 4'b0010); add_ev(6, 19, 4'b0010); add_ev(6, 22, 4'b0010); add_ev(6, 25, 4'b0010);
`endif
    def_row(7, 4'b1000, 20); add_ev(7, 8, 4'b1000);

    for (r = 0; r < 8; r++) run_row(r);

    // Simultaneous up/right/confirm: pulses in priority order, pending drains.
    base = cyc;
    set_btn(4'b1011);
    push(base + 8, 4'b1000);
    push(base + 9, 4'b0010);
    push(base + 10, 4'b0001);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7)  check4("pend_k7", bus.pending_o, 4'b1011);
      if (k == 8)  check4("pend_k8", bus.pending_o, 4'b0011);
      if (k == 9)  check4("pend_k9", bus.pending_o, 4'b0001);
      if (k == 10) begin
        check4("pend_k10", bus.pending_o, 4'b0000);
        set_btn(4'b0000);
      end
    end
    while (cyc < base + 40) tick();
    check_q_empty("prio_pulses_seen");

    // Right bouncing 2 high / 2 low five times: nothing may come out.
    for (int k = 0; k < 5; k++) begin
      set_btn(4'b0010);
      repeat (2) tick();
      set_btn(4'b0000);
      repeat (2) tick();
    end
    repeat (20) tick();
    check4("pend_bounce", bus.pending_o, 4'b0000);

    // Reset two cycles into a confirm debounce, button still held after release.
    base = cyc;
    set_btn(4'b0001);
    repeat (4) tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      check4("pend_mid_reset", bus.pending_o, 4'b0000);
    end
    rst = 1'b1;
    base = cyc;
    push(base + 8, 4'b0001);
    repeat (12) tick();
    set_btn(4'b0000);
    while (cyc < base + 30) tick();
    check4("pend_after_rst_seq", bus.pending_o, 4'b0000);
    check_q_empty("rst_pulses_seen");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
